// File: rtl/regfile_write_scheduler_pkg.sv
// regfile_write_scheduler_pkg: shared register-file geometry and writeback source encoding.
package regfile_write_scheduler_pkg;
    localparam int REGISTER_WIDTH = 5;
    localparam int X_LENGTH       = 32;
    localparam int REGISTER_COUNT = 32;
    typedef enum logic {WB_SRC_EXE = 1'b0, WB_SRC_MEM = 1'b1} wb_src_e;
endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way writeback arbiter, round-robin or fixed memory priority.
module rr_arbiter2
    import regfile_write_scheduler_pkg::*;
#(
    parameter int RR_ENABLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic exe_req_i,
    input  logic mem_req_i,
    output logic exe_gnt_o,
    output logic mem_gnt_o
);
    wb_src_e last_q, last_d;
    // Memory wins a conflict when fixed priority is selected or execute went last.
    always_comb begin
        mem_gnt_o = mem_req_i && (!exe_req_i || RR_ENABLE == 0 || last_q == WB_SRC_EXE);
        exe_gnt_o = exe_req_i && !mem_gnt_o;
        last_d    = mem_gnt_o ? WB_SRC_MEM : exe_gnt_o ? WB_SRC_EXE : last_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= WB_SRC_MEM;
        else        last_q <= last_d;
    end
endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates exe/mem writebacks onto one registered rd port
// and tracks pending destinations in a scoreboard for decode hazard stalls.
module regfile_write_scheduler
    import regfile_write_scheduler_pkg::*;
#(
    parameter int RR_ENABLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_valid,
    input  logic [REGISTER_WIDTH-1:0] issue_rd,
    output logic                      issue_ready,
    input  logic [REGISTER_WIDTH-1:0] rs1_index,
    input  logic [REGISTER_WIDTH-1:0] rs2_index,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    input  logic                      exe_valid,
    output logic                      exe_ready,
    input  logic [REGISTER_WIDTH-1:0] exe_index,
    input  logic [X_LENGTH-1:0]       exe_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [REGISTER_WIDTH-1:0] mem_index,
    input  logic [X_LENGTH-1:0]       mem_data,
    output logic                      rd_write_enable,
    output logic [REGISTER_WIDTH-1:0] rd_write_index,
    output logic [X_LENGTH-1:0]       rd_write_data,
    output logic [REGISTER_COUNT-1:0] busy_vector
);
    logic [REGISTER_COUNT-1:0] busy_q, busy_d, set_mask, clr_mask;
    logic                      we_q, we_d;
    logic [REGISTER_WIDTH-1:0] idx_q, idx_d;
    logic [X_LENGTH-1:0]       data_q, data_d;

    rr_arbiter2 #(.RR_ENABLE(RR_ENABLE)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .exe_req_i (exe_valid),
        .mem_req_i (mem_valid),
        .exe_gnt_o (exe_ready),
        .mem_gnt_o (mem_ready)
    );

    assign issue_ready     = !busy_q[issue_rd];
    assign rs1_busy        = busy_q[rs1_index];
    assign rs2_busy        = busy_q[rs2_index];
    assign rd_write_enable = we_q;
    assign rd_write_index  = idx_q;
    assign rd_write_data   = data_q;
    assign busy_vector     = busy_q;

    // Set is applied after clear so a new producer keeps its register pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && issue_ready) set_mask[issue_rd] = 1'b1;
        if (we_q) clr_mask[idx_q] = 1'b1;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
        idx_d     = exe_ready ? exe_index : mem_index;
        data_d    = exe_ready ? exe_data : mem_data;
        we_d      = (exe_ready || mem_ready) && idx_d != '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            we_q   <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            busy_q <= busy_d;
            we_q   <= we_d;
            if (we_d) begin
                idx_q  <= idx_d;
                data_q <= data_d;
            end
        end
    end
endmodule
